// File: rtl/fir_out_capture_if.sv
// FIR output capture bus: the incoming FIR sample stream and the readout
// stream with its ready/valid handshake. The capture block uses the slave
// view; whatever produces samples and consumes readout uses the master view.
interface fir_cap_if #(
  parameter int Y_SIZE     = 26,
  parameter int INDEX_SIZE = 8
);
  logic [Y_SIZE-1:0]     din;
  logic [INDEX_SIZE-1:0] din_index;
  logic                  din_valid;
  logic [Y_SIZE-1:0]     out_data;
  logic [INDEX_SIZE-1:0] out_addr;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output din, din_index, din_valid, out_ready,
    input  out_data, out_addr, out_valid
  );

  modport slave (
    input  din, din_index, din_valid, out_ready,
    output out_data, out_addr, out_valid
  );
endinterface

// File: rtl/fir_out_capture.sv
// fir_out_capture: captures 2**INDEX_SIZE FIR output samples into a buffer
// indexed by the sample index, then streams the buffer out in address order
// over a ready/valid handshake.
// Optional feature macro: FIR_CAP_CHECKSUM_EN adds a 32-bit running sum of
// the sign-extended samples written during a capture; without it the
// checksum output is tied to zero.
module fir_out_capture #(
  parameter int Y_SIZE     = 26,
  parameter int INDEX_SIZE = 8
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  fir_cap_if.slave            bus,
  input  logic                i_cap_start,
  input  logic                i_cap_abort,
  input  logic                i_rd_start,
  output logic [INDEX_SIZE:0] o_cap_count,
  output logic                o_done,
  output logic                o_busy,
  output logic [31:0]         o_checksum
);

  localparam int DEPTH = 2 ** INDEX_SIZE;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_READOUT = 2'd3;

  localparam logic [INDEX_SIZE-1:0] LAST_ADDR = {INDEX_SIZE{1'b1}};
  localparam logic [INDEX_SIZE:0]   LAST_CNT  = {1'b0, {INDEX_SIZE{1'b1}}};
  localparam logic [INDEX_SIZE-1:0] ADDR_ONE  = {{(INDEX_SIZE-1){1'b0}}, 1'b1};
  localparam logic [INDEX_SIZE:0]   CNT_ONE   = {{INDEX_SIZE{1'b0}}, 1'b1};

  logic [Y_SIZE-1:0]     r_mem [0:DEPTH-1];
  logic [1:0]            r_state;
  logic [INDEX_SIZE:0]   r_cap_count;
  logic                  r_done;
  logic                  r_busy;
  logic [Y_SIZE-1:0]     r_out_data;
  logic [INDEX_SIZE-1:0] r_out_addr;
  logic                  r_out_valid;

  logic [1:0]            w_state_nxt;
  logic                  w_wr_en;
  logic                  w_cap_clr;
  logic                  w_rd_load;
  logic                  w_xfer;
  logic                  w_last_xfer;
  logic                  w_fetch;
  logic [INDEX_SIZE-1:0] w_rd_addr;

  // Qualify events against the current state and pick the next state; abort overrides everything.
  always_comb begin
    w_wr_en     = 1'b0;
    w_cap_clr   = 1'b0;
    w_rd_load   = 1'b0;
    w_xfer      = 1'b0;
    w_last_xfer = 1'b0;
    w_fetch     = 1'b0;
    w_rd_addr   = {INDEX_SIZE{1'b0}};
    w_state_nxt = r_state;

    w_wr_en     = (r_state == ST_CAPTURE) && bus.din_valid && !i_cap_abort;
    w_cap_clr   = (r_state == ST_IDLE) && i_cap_start && !i_cap_abort;
    w_rd_load   = (r_state == ST_DONE) && i_rd_start && !i_cap_abort;
    w_xfer      = (r_state == ST_READOUT) && r_out_valid && bus.out_ready && !i_cap_abort;
    w_last_xfer = w_xfer && (r_out_addr == LAST_ADDR);
    // A transfer immediately fetches the next word so readout has no bubble.
    w_fetch     = w_rd_load || (w_xfer && !w_last_xfer);

    if (w_rd_load) begin
      w_rd_addr = {INDEX_SIZE{1'b0}};
    end else begin
      w_rd_addr = r_out_addr + ADDR_ONE;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_cap_clr) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (w_wr_en && (r_cap_count == LAST_CNT)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (w_rd_load) begin
          w_state_nxt = ST_READOUT;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_READOUT: begin
        if (w_last_xfer) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_READOUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (i_cap_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Sample buffer write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en && i_rstn) begin
      r_mem[bus.din_index] <= bus.din;
    end
  end

  // State, capture counter, status flags and the registered readout stage.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_cap_count <= {(INDEX_SIZE+1){1'b0}};
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= {Y_SIZE{1'b0}};
      r_out_addr  <= {INDEX_SIZE{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt == ST_CAPTURE) || (w_state_nxt == ST_READOUT);

      if (i_cap_abort || w_cap_clr) begin
        r_cap_count <= {(INDEX_SIZE+1){1'b0}};
      end else if (w_wr_en) begin
        r_cap_count <= r_cap_count + CNT_ONE;
      end

      if (i_cap_abort || w_last_xfer) begin
        r_out_valid <= 1'b0;
      end else if (w_rd_load) begin
        r_out_valid <= 1'b1;
      end

      if (w_fetch) begin
        r_out_data <= r_mem[w_rd_addr];
        r_out_addr <= w_rd_addr;
      end
    end
  end

`ifdef FIR_CAP_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Sign-extend (or wrap) a sample into the 32-bit checksum domain.
  function automatic logic [31:0] sext32(input logic [Y_SIZE-1:0] v);
    return 32'($signed(v));
  endfunction

  // Running sum of accepted samples, restarted by each new capture.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_checksum <= 32'd0;
    end else if (w_cap_clr) begin
      r_checksum <= 32'd0;
    end else if (w_wr_en) begin
      r_checksum <= r_checksum + sext32(bus.din);
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = 32'd0;
`endif

  assign o_cap_count   = r_cap_count;
  assign o_done        = r_done;
  assign o_busy        = r_busy;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_fir_out_capture.sv
// Directed bench for fir_out_capture: fill/readout, stalled readout,
// abort, checksum and reset-during-readout scenarios.
module tb_fir_out_capture;
  localparam int YS = 26;
  localparam int IS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          cap_start;
  logic          cap_abort;
  logic          rd_start;
  logic [IS:0]   cap_count;
  logic          done;
  logic          busy;
  logic [31:0]   checksum;

  int n_total = 0;
  int n_bad   = 0;

  fir_cap_if #(.Y_SIZE(YS), .INDEX_SIZE(IS)) bus ();

  fir_out_capture #(.Y_SIZE(YS), .INDEX_SIZE(IS)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .bus         (bus),
    .i_cap_start (cap_start),
    .i_cap_abort (cap_abort),
    .i_rd_start  (rd_start),
    .o_cap_count (cap_count),
    .o_done      (done),
    .o_busy      (busy),
    .o_checksum  (checksum)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample value for a given capture pattern and buffer address.
  function automatic logic [YS-1:0] data_of(input int kind, input int addr);
    logic [YS-1:0] v;
    if (kind == 0)      v = YS'(addr * 3);
    else if (kind == 1) v = YS'(addr * 5 + 7);
    else                v = {YS{1'b1}};
    return v;
  endfunction

  function automatic logic [31:0] exp_ck(input logic [31:0] v);
`ifdef FIR_CAP_CHECKSUM_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // Start a capture and write all 256 entries; kind 1 writes in reverse index order.
  task automatic fill(input int kind);
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_count", 64'(cap_count), 64'd0);
    for (int i = 0; i < 256; i++) begin
      automatic int idx = (kind == 1) ? (255 - i) : i;
      bus.din_valid = 1'b1;
      bus.din_index = IS'(idx);
      bus.din       = data_of(kind, idx);
      tick();
      if (i == 254) begin
        chk("cnt_255", 64'(cap_count), 64'd255);
        chk("done_early", 64'(done), 64'd0);
      end
    end
    bus.din_valid = 1'b0;
    chk("fill_done", 64'(done), 64'd1);
    chk("fill_busy", 64'(busy), 64'd0);
    chk("fill_count", 64'(cap_count), 64'd256);
  endtask

  initial begin
    automatic logic ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    automatic int e = 0;
    automatic int k = 0;

    rstn = 1'b0; cap_start = 1'b0; cap_abort = 1'b0; rd_start = 1'b0;
    bus.din = '0; bus.din_index = '0; bus.din_valid = 1'b0; bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_addr", 64'(bus.out_addr), 64'd0);
    chk("rst_count", 64'(cap_count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ck", 64'(checksum), 64'd0);
    rstn = 1'b1;

    // rd_start and din_valid in IDLE do nothing
    rd_start = 1'b1; bus.din_valid = 1'b1;
    tick();
    rd_start = 1'b0; bus.din_valid = 1'b0;
    chk("idle_rd_busy", 64'(busy), 64'd0);
    chk("idle_rd_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_count", 64'(cap_count), 64'd0);

    // Full capture of index*3
    fill(0);
    chk("ck_fill0", 64'(checksum), 64'(exp_ck(32'd97920)));
    // writes and cap_start ignored in DONE
    bus.din_valid = 1'b1; bus.din_index = '0; bus.din = 26'd999; cap_start = 1'b1;
    tick();
    bus.din_valid = 1'b0; cap_start = 1'b0;
    chk("done_hold", 64'(done), 64'd1);
    chk("done_count", 64'(cap_count), 64'd256);
    chk("done_valid", 64'(bus.out_valid), 64'd0);

    // Streaming readout with out_ready held high
    rd_start = 1'b1; bus.out_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int a = 0; a < 256; a++) begin
      chk("rd_valid", 64'(bus.out_valid), 64'd1);
      chk("rd_addr", 64'(bus.out_addr), 64'(a));
      chk("rd_data", 64'(bus.out_data), 64'(data_of(0, a)));
      tick();
    end
    chk("rd_end_valid", 64'(bus.out_valid), 64'd0);
    chk("rd_end_busy", 64'(busy), 64'd0);
    chk("rd_end_done", 64'(done), 64'd0);
    chk("rd_end_count", 64'(cap_count), 64'd256);
    bus.out_ready = 1'b0;

    // Reverse-order capture, then readout with ready 1,0,0,1
    fill(1);
    chk("ck_fill1", 64'(checksum), 64'(exp_ck(32'd164992)));
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    while (e < 256 && k < 3000) begin
      bus.out_ready = ready_pat[k % 4];
      chk("st_valid", 64'(bus.out_valid), 64'd1);
      chk("st_addr", 64'(bus.out_addr), 64'(e));
      chk("st_data", 64'(bus.out_data), 64'(data_of(1, e)));
      tick();
      if (bus.out_ready) e++;
      k++;
    end
    bus.out_ready = 1'b0;
    chk("st_all", 64'(e), 64'd256);
    chk("st_end_valid", 64'(bus.out_valid), 64'd0);
    chk("st_end_busy", 64'(busy), 64'd0);

    // Abort together with cap_start at write 100
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.din_valid = 1'b1; bus.din_index = IS'(i); bus.din = {YS{1'b1}};
      tick();
    end
    chk("ab_count100", 64'(cap_count), 64'd100);
    bus.din_index = 8'd100; cap_abort = 1'b1; cap_start = 1'b1;
    tick();
    cap_abort = 1'b0; cap_start = 1'b0; bus.din_valid = 1'b0;
    chk("ab_count", 64'(cap_count), 64'd0);
    chk("ab_valid", 64'(bus.out_valid), 64'd0);
    chk("ab_done", 64'(done), 64'd0);
    chk("ab_busy", 64'(busy), 64'd0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("ab_rd_valid", 64'(bus.out_valid), 64'd0);
    chk("ab_rd_busy", 64'(busy), 64'd0);

    // All -1 capture for the checksum, then reset mid-readout at address 17
    fill(2);
    chk("ck_minus1", 64'(checksum), 64'(exp_ck(32'hFFFFFF00)));
    rd_start = 1'b1; bus.out_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk("r17_addr", 64'(bus.out_addr), 64'd17);
    chk("r17_data", 64'(bus.out_data), 64'(data_of(2, 17)));
    rstn = 1'b0;
    tick();
    rstn = 1'b1; bus.out_ready = 1'b0;
    chk("mrst_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_data", 64'(bus.out_data), 64'd0);
    chk("mrst_addr", 64'(bus.out_addr), 64'd0);
    chk("mrst_count", 64'(cap_count), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ck", 64'(checksum), 64'd0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    chk("post_rd_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rd_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_out_capture.md
FIR_OUT_CAPTURE -- requirements
Module: fir_out_capture

Interface
REQ-001 Parameter Y_SIZE, default 26, SHALL be the FIR output sample width (Q26.22 two's complement).
REQ-002 Parameter INDEX_SIZE, default 8, SHALL be the sample index width; buffer depth SHALL be 2**INDEX_SIZE (256).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  SHALL be the synchronous, active-low reset.
REQ-005 din  input  Y_SIZE  SHALL carry the registered FIR output sample.
REQ-006 din_index  input  INDEX_SIZE  SHALL carry the registered FIR output index.
REQ-007 din_valid  input  1  SHALL qualify din/din_index for the current cycle.
REQ-008 cap_start  input  1  SHALL be a one-cycle request to begin a capture.
REQ-009 cap_abort  input  1  SHALL force a return to IDLE.
REQ-010 rd_start  input  1  SHALL be a one-cycle request to begin readout.
REQ-011 out_ready  input  1  SHALL be the downstream readiness for readout data.
REQ-012 out_data  output  Y_SIZE  SHALL carry the buffered sample being read out.
REQ-013 out_addr  output  INDEX_SIZE  SHALL carry the buffer address of out_data.
REQ-014 out_valid  output  1  SHALL qualify out_data/out_addr.
REQ-015 cap_count  output  INDEX_SIZE+1  SHALL report samples written in the current capture.
REQ-016 done  output  1  SHALL be high while in DONE.
REQ-017 busy  output  1  SHALL be high in CAPTURE or READOUT.
REQ-018 checksum  output  32  SHALL report the running sample checksum (see Configuration).

Function
REQ-019 FSM states SHALL be IDLE, CAPTURE, DONE, READOUT.
REQ-020 IDLE: cap_start=1 SHALL move to CAPTURE next cycle and clear cap_count to 0; rd_start SHALL be ignored.
REQ-021 CAPTURE: each cycle with din_valid=1 SHALL write din to mem[din_index] and increment cap_count.
REQ-022 A repeated din_index SHALL overwrite the prior entry and still increment cap_count.
REQ-023 The write that brings cap_count to 256 SHALL cause transition to DONE next cycle; no further writes occur.
REQ-024 din_valid SHALL be ignored outside CAPTURE; cap_start SHALL be ignored outside IDLE.
REQ-025 DONE: rd_start=1 SHALL move to READOUT with read address 0; cap_start SHALL be ignored.
REQ-026 READOUT: out_valid SHALL rise exactly one cycle after rd_start (registered memory read).
REQ-027 out_data/out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 A transfer (out_valid & out_ready) SHALL present the next address's data the following cycle with no bubble.
REQ-029 Transfer of address 255 SHALL drop out_valid and return to IDLE next cycle; cap_count retained until next cap_start.
REQ-030 cap_abort=1 in any state SHALL go to IDLE next cycle, drop out_valid, clear cap_count; memory contents retained; abort SHALL win over simultaneous cap_start or rd_start.
REQ-031 out_valid SHALL be 0 in every state except READOUT.

Reset
REQ-032 rstn=0 at a clock edge SHALL set state IDLE, out_data=0, out_addr=0, out_valid=0, cap_count=0, done=0, busy=0, checksum=0.
REQ-033 Reset mid-CAPTURE or mid-READOUT SHALL behave as REQ-032; memory contents need not be cleared.

Configuration
REQ-034 Macro FIR_CAP_CHECKSUM_EN defined: checksum SHALL be cleared on cap_start and add sign-extended din (modulo 2**32) on every accepted write.
REQ-035 Macro FIR_CAP_CHECKSUM_EN undefined: checksum SHALL be constant 0 and no accumulator logic SHALL be instantiated.

Verification
REQ-036 Reset, cap_start, din_valid=1 for 256 cycles with din_index=0..255 and din=index*3 -> done=1 one cycle after the 256th write, cap_count=256.
REQ-037 After REQ-036, rd_start with out_ready=1 -> out_valid from the next cycle for 256 consecutive cycles, out_addr 0..255, out_data=addr*3, then IDLE.
REQ-038 Readout with out_ready toggling 1,0,0,1 -> each address presented once, data held during stalls, no loss or duplication.
REQ-039 cap_abort together with cap_start at write 100 -> IDLE next cycle, cap_count=0, out_valid=0, done=0.
REQ-040 FIR_CAP_CHECKSUM_EN defined, din=-1 for all 256 writes -> checksum=0xFFFFFF00; undefined -> checksum=0.
REQ-041 rstn=0 during READOUT at address 17 -> all outputs at reset values next cycle; rd_start then ignored until a new capture completes.
